// File: rtl/water_pkg.sv
// Shared definitions for the reading formatter.
//   fmt_state_t  : converter FSM states
//   BLANK_NIBBLE : display code for an unlit digit
//   DISP_DIGITS  : digits on the downstream display
//   BCD_DIGITS   : decimal digits needed for a 16-bit reading
package water_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, FORMAT} fmt_state_t;

  localparam logic [3:0]  BLANK_NIBBLE = 4'hF;
  localparam int unsigned DISP_DIGITS  = 8;
  localparam int unsigned BCD_DIGITS   = 5;
  localparam int unsigned BIN_W        = 16;

endpackage

// File: rtl/reading_formatter_if.sv
// Handshake/data bundle between a reading source and reading_formatter.
//   start, value      : conversion request and raw reading (source -> formatter)
//   number, dp_list   : packed display digits and decimal-point mask
//   busy, done        : conversion in progress / one-cycle result strobe
interface reading_formatter_if;
  logic        start;
  logic [15:0] value;
  logic [31:0] number;
  logic [7:0]  dp_list;
  logic        busy;
  logic        done;

  modport master (
    output start, value,
    input  number, dp_list, busy, done
  );

  modport slave (
    input  start, value,
    output number, dp_list, busy, done
  );
endinterface

// File: rtl/bcd_add3.sv
// Double-dabble digit adjust: a BCD digit of 5 or more gets 3 added so the
// following left shift carries correctly into the next decimal digit.
//   digit_i : BCD digit before adjust
//   digit_o : adjusted digit
module bcd_add3 (
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);
  assign digit_o = (digit_i >= 4'd5) ? digit_i + 4'd3 : digit_i;
endmodule

// File: rtl/reading_formatter.sv
// Converts a 16-bit fixed-point reading into an 8-digit packed display word
// with leading-zero blanking and a decimal-point mask.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of reading_formatter_if (start/value in,
//              number/dp_list/busy/done out)
// Timing: start accepted on edge N, 16 shift edges N+1..N+16, result and
// done on edge N+17.
module reading_formatter
  import water_pkg::*;
#(
  parameter int unsigned FRAC_DIGITS = 2
) (
  input  logic               clk,
  input  logic               rst,
  reading_formatter_if.slave bus
);

  fmt_state_t  state_q, state_d;
  logic [15:0] bin_q, bin_d;
  logic [19:0] bcd_q, bcd_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] number_q, number_d;
  logic [7:0]  dp_q, dp_d;
  logic        done_q, done_d;

  logic [19:0] bcd_adj;
  logic [31:0] fmt_word;
  logic [7:0]  dp_mask;
  logic        blanking;
  logic [3:0]  digit;

  for (genvar g = 0; g < int'(BCD_DIGITS); g++) begin : g_add3
    bcd_add3 u_add3 (
      .digit_i(bcd_q[4*g +: 4]),
      .digit_o(bcd_adj[4*g +: 4])
    );
  end

  // Blank leading zeros from the top digit down, stopping at the first
  // nonzero digit; the units digit and the fractional digits always show.
  always_comb begin
    fmt_word = '1;
    blanking = 1'b1;
    digit    = 4'd0;
    for (int i = int'(BCD_DIGITS) - 1; i >= 0; i--) begin
      digit = bcd_q[4*i +: 4];
      if (blanking && (i > int'(FRAC_DIGITS)) && (digit == 4'd0)) begin
        fmt_word[4*i +: 4] = BLANK_NIBBLE;
      end else begin
        fmt_word[4*i +: 4] = digit;
        blanking           = 1'b0;
      end
    end
  end

  assign dp_mask = (FRAC_DIGITS > 0) ? 8'(8'd1 << FRAC_DIGITS) : 8'h00;

  always_comb begin
    state_d  = state_q;
    bin_d    = bin_q;
    bcd_d    = bcd_q;
    cnt_d    = cnt_q;
    number_d = number_q;
    dp_d     = dp_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          bin_d   = bus.value;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
        cnt_d          = cnt_q + 5'd1;
        if (cnt_q == 5'd15) begin
          state_d = FORMAT;
        end
      end
      FORMAT: begin
        number_d = fmt_word;
        dp_d     = dp_mask;
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      bin_q    <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
      number_q <= '1;
      dp_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bin_q    <= bin_d;
      bcd_q    <= bcd_d;
      cnt_q    <= cnt_d;
      number_q <= number_d;
      dp_q     <= dp_d;
      done_q   <= done_d;
    end
  end

  assign bus.number  = number_q;
  assign bus.dp_list = dp_q;
  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = done_q;

endmodule

// File: doc/reading_formatter.md
# reading_formatter

Converts an unsigned 16-bit sensor reading, in fixed-point units of 10^-FRAC_DIGITS, into the 8-digit packed display word and decimal-point mask consumed by `controller`. It sits directly upstream of `controller` and drives its `number` and `dp_list` inputs. Conversion is an iterative shift-and-add-3 (double dabble), followed by leading-zero blanking.

## Interface
- `FRAC_DIGITS`, default 2: number of fractional digits, legal 0..4. Sets the decimal-point position.
- `clk` in 1: system clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: request a conversion. Sampled only in IDLE.
- `value` in 16: raw reading, 0..65535. Sampled on the accepting edge.
- `number` out 32: packed digits, nibble i = `number[4i+3:4i]`, digit 0 rightmost. Nibble 4'hF = blank.
- `dp_list` out 8: bit i lights the decimal point of digit i.
- `busy` out 1: high while state ≠ IDLE.
- `done` out 1: single-cycle pulse when `number`/`dp_list` update.

## Operation
- States:
  - IDLE: wait for `start`. `start`=1 → load `value` into the shift register, clear the 20-bit BCD accumulator and the 5-bit counter, go to SHIFT.
  - SHIFT: each cycle, add 3 to every BCD digit ≥5, then shift {bcd, bin} left by 1. After 16 shifts (counter = 15 on that edge) go to FORMAT.
  - FORMAT: build the output word, register `number`/`dp_list`, assert `done`, go to IDLE.
- Output word:
  - Digits 4..0 = BCD result. Nibbles 7..5 are always 4'hF.
  - Leading-zero blanking: scan from digit 4 down to digit FRAC_DIGITS+1. Each zero digit becomes 4'hF until the first nonzero digit.
  - Digit FRAC_DIGITS and all digits below it are never blanked.
- `dp_list` = one-hot bit FRAC_DIGITS when FRAC_DIGITS > 0, else 8'h00.
- Width rules:
  - 16 bits needs at most 5 digits (65535), so no overflow or saturation path exists.
  - BCD accumulator is 20 bits; combined shift register is 36 bits.
- `number` and `dp_list` hold their last value between conversions.
- `start` while busy is ignored and not queued.
- `value` changes after the accepting edge do not affect the result.

## Timing
- Reset values: `number`=32'hFFFF_FFFF (all blank), `dp_list`=8'h00, `busy`=0, `done`=0, state=IDLE.
- `rst` mid-conversion aborts immediately. Outputs return to their reset values and the result is discarded.
- Latency: `start` accepted on edge N.
  - `busy`=1 after N.
  - Shifts occur on edges N+1..N+16.
  - On edge N+17: `number`/`dp_list` update, `done`=1 and `busy`=0 for the following cycle.
- Throughput: `start` held high gives a new acceptance on edge N+18, i.e. one result every 18 cycles.
- `done` is high for exactly one cycle and coincides with the new output values.

## Structure
- Shared package `water_pkg` holds:
  - state enum `fmt_state_t` {IDLE, SHIFT, FORMAT};
  - `BLANK_NIBBLE` = 4'hF;
  - `DISP_DIGITS` = 8.
- One sub-module, `bcd_add3`: 4-bit combinational digit adjust (≥5 → +3). Five instances, one per BCD digit.
- Blanking and dp-mask generation are combinational logic feeding registers in FORMAT.

## Test plan
- Reset, then `value`=1234, FRAC_DIGITS=2 → `done` at edge N+17 with `number`=32'hFFFF1234 and `dp_list`=8'b0000_0100 ("12.34").
- `value`=5 → `number`=32'hFFFFF005, `dp_list`=8'h04 ("0.05"). `value`=0 → 32'hFFFFF000.
- `value`=65535 → `number`=32'hFFF65535. With FRAC_DIGITS=0, `value`=7 → `number`=32'hFFFFFFF7 and `dp_list`=8'h00.
- Pulse `start` again at N+5 with a different `value` → ignored. Result matches the first `value`, with exactly one `done`.
- Assert `rst` at N+8 → `busy`=0 and `number`=32'hFFFFFFFF immediately, no `done`. A fresh `start` then converts correctly.
- Hold `start`=1 with `value` stepping 100, 200 → `done` pulses 18 cycles apart with 32'hFFFFF100 then 32'hFFFFF200.
